// File: rtl/bft_pkg.sv
// Shared packet layout helpers for the butterfly-fat-tree client port.
// A packet is {tag, addr, data}, with the tag in the MSB.
package bft_pkg;

  function automatic int pkt_w(input int a_w, input int d_w);
    return a_w + d_w + 1;
  endfunction

  function automatic int tag_bit(input int a_w, input int d_w);
    return a_w + d_w;
  endfunction

  function automatic int addr_lo(input int d_w);
    return d_w;
  endfunction

endpackage

// File: rtl/bft_client_port_if.sv
// Local-side and switch-side handshake bundle of a BFT client port.
// The master modport is the environment (processing element plus switch); the slave modport is the port.
interface bft_client_port_if
  import bft_pkg::*;
#(
  parameter int A_W = 3,
  parameter int D_W = 32
);
  logic [A_W-1:0]              tx_addr;
  logic [D_W-1:0]              tx_data;
  logic                        tx_v;
  logic                        tx_rdy;
  logic [pkt_w(A_W, D_W)-1:0]  o;
  logic                        o_v;
  logic                        o_bp;
  logic [pkt_w(A_W, D_W)-1:0]  i;
  logic                        i_v;
  logic                        i_bp;
  logic [D_W-1:0]              rx_data;
  logic                        rx_v;
  logic                        rx_rdy;

  modport master (
    output tx_addr, tx_data, tx_v, o_bp, i, i_v, rx_rdy,
    input  tx_rdy, o, o_v, i_bp, rx_data, rx_v
  );

  modport slave (
    input  tx_addr, tx_data, tx_v, o_bp, i, i_v, rx_rdy,
    output tx_rdy, o, o_v, i_bp, rx_data, rx_v
  );
endinterface

// File: rtl/bft_fifo.sv
// Synchronous FIFO with a wrap-bit pointer scheme; head is read straight from storage.
// Pushes while full are ignored, so a same-cycle pop on a full FIFO only frees a slot.
module bft_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_din,
  output logic         o_full,
  output logic         o_empty,
  output logic [W-1:0] o_head
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr;
  logic [AW:0]  r_rd;
  logic         w_push;
  logic         w_pop;

  assign o_empty = (r_wr == r_rd);
  assign o_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_head  = r_mem[r_rd[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
    end
  end

  // Storage needs no reset: the head is only observed while non-empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr[AW-1:0]] <= i_din;
  end
endmodule

// File: rtl/bft_client_port.sv
// Leaf endpoint of the butterfly-fat-tree: TX/RX buffering between a processing element and a switch port,
// plus transfer counters, a sticky error flag and a registered idle indication.
module bft_client_port
  import bft_pkg::*;
#(
  parameter int N     = 4,
  parameter int A_W   = $clog2(N) + 1,
  parameter int D_W   = 32,
  parameter int posx  = 0,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  bft_client_port_if.slave bus,
  output logic [CNT_W-1:0] tx_cnt,
  output logic [CNT_W-1:0] rx_cnt,
  output logic             err,
  output logic             done
);
  localparam logic [A_W-1:0] POSX    = A_W'(posx);
  localparam int             TAG_B   = tag_bit(A_W, D_W);
  localparam int             ADDR_LO = addr_lo(D_W);

  logic               w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
  logic [A_W+D_W-1:0] w_tx_head;
  logic [D_W-1:0]     w_rx_head;
  logic               w_tx_acc, w_self_send, w_tx_push, w_tx_pop;
  logic               w_rx_push, w_rx_bad, w_rx_pop;
  logic [A_W-1:0]     w_rx_addr;
  logic [CNT_W-1:0]   r_tx_cnt, r_rx_cnt;
  logic               r_err, r_done;

  assign w_tx_acc    = ce & bus.tx_v & ~w_tx_full;
  assign w_self_send = w_tx_acc & (bus.tx_addr == POSX);
  assign w_tx_push   = w_tx_acc & (bus.tx_addr != POSX);
  assign w_tx_pop    = ce & ~w_tx_empty & ~bus.o_bp;

  assign w_rx_addr   = bus.i[ADDR_LO +: A_W];
  assign w_rx_push   = ce & bus.i_v & ~w_rx_full;
  assign w_rx_bad    = w_rx_push & (~bus.i[TAG_B] | (w_rx_addr != POSX));
  assign w_rx_pop    = ce & ~w_rx_empty & bus.rx_rdy;

  bft_fifo #(.W(A_W + D_W), .DEPTH(DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_tx_push),
    .i_pop   (w_tx_pop),
    .i_din   ({bus.tx_addr, bus.tx_data}),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty),
    .o_head  (w_tx_head)
  );

  bft_fifo #(.W(D_W), .DEPTH(DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_rx_push),
    .i_pop   (w_rx_pop),
    .i_din   (bus.i[D_W-1:0]),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty),
    .o_head  (w_rx_head)
  );

  // Outputs are forced to zero while empty so reset values appear without a clock edge.
  assign bus.tx_rdy  = ~w_tx_full;
  assign bus.o_v     = ~w_tx_empty;
  assign bus.o       = w_tx_empty ? '0 : {1'b1, w_tx_head};
  assign bus.i_bp    = w_rx_full;
  assign bus.rx_v    = ~w_rx_empty;
  assign bus.rx_data = w_rx_empty ? '0 : w_rx_head;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_cnt <= '0;
      r_rx_cnt <= '0;
      r_err    <= 1'b0;
      r_done   <= 1'b0;
    end else if (ce) begin
      if (w_tx_pop)  r_tx_cnt <= r_tx_cnt + 1'b1;
      if (w_rx_push) r_rx_cnt <= r_rx_cnt + 1'b1;
      if (w_self_send | w_rx_bad) r_err <= 1'b1;
      r_done <= w_tx_empty & w_rx_empty & ~bus.i_v & ~bus.tx_v;
    end
  end

  assign tx_cnt = r_tx_cnt;
  assign rx_cnt = r_rx_cnt;
  assign err    = r_err;
  assign done   = r_done;
endmodule
